// File: rtl/sm_dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package sm_dmem_arbiter_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 32;
  localparam int BW_DEF = DW_DEF / 8;

  // Access sequencer states: latch in IDLE, strobe the RAM in ISSUE,
  // capture read data in WAIT.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Byte-enable patterns used by the CPU load/store path.
  localparam logic [BW_DEF-1:0] BE_WORD    = 4'b1111;
  localparam logic [BW_DEF-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [BW_DEF-1:0] BE_HALF_HI = 4'b1100;

endpackage

// File: rtl/sm_dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request fields plus the
// grant / completion handshake.
interface sm_dmem_arbiter_if
  import sm_dmem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int BW = BW_DEF
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [BW-1:0] be;
  logic          gnt;
  logic          rvalid;

  // Requester side: holds req and fields stable until gnt.
  modport master (output req, we, addr, wdata, be, input gnt, rvalid);

  // Arbiter side.
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid);

endinterface

// File: rtl/sm_rr_arb2.sv
// Two-way round-robin pick. The pick is combinational; the last winner is
// registered and advances only when the sequencer actually latches a request.
module sm_rr_arb2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_update,
  output logic o_any,
  output logic o_pick
);

  logic r_last_winner;

  // Choose a winner: a lone requester wins, a tie goes to the port that
  // did not win last time.
  always_comb begin
    // NOTE: every output gets a default before the branches so no path
    // leaves it unassigned, which would otherwise infer a latch.
    o_any  = i_req0 | i_req1;
    o_pick = 1'b0;
    if (i_req0 && i_req1) begin
      o_pick = ~r_last_winner;
    end else if (i_req1) begin
      o_pick = 1'b1;
    end
  end

  // Remember who won; port 1 is the reset value so port 0 wins the first tie.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // independent of the order the always blocks are evaluated in.
    if (i_rst) begin
      r_last_winner <= 1'b1;
    end else if (i_update) begin
      r_last_winner <= o_pick;
    end
  end

endmodule

// File: rtl/sm_dmem_arbiter.sv
// Shares one synchronous-read data RAM between the CPU load/store port (p0)
// and the debug/loader port (p1). Each access runs IDLE -> ISSUE -> WAIT and
// completes with a one-cycle rvalid pulse back in IDLE, so a new request can
// be latched in the same cycle the previous one completes.
module sm_dmem_arbiter
  import sm_dmem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int BW = BW_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sm_dmem_arbiter_if.slave     p0_if,
  sm_dmem_arbiter_if.slave     p1_if,
  output logic [DW-1:0]        o_rdata,
  output logic                 o_busy,
  output logic                 o_mem_en,
  output logic                 o_mem_we,
  output logic [AW-1:0]        o_mem_addr,
  output logic [DW-1:0]        o_mem_wdata,
  output logic [BW-1:0]        o_mem_be,
  input  logic [DW-1:0]        i_mem_rdata
);

  state_t        r_state;
  state_t        w_next_state;
  logic          w_latch;
  logic          w_any;
  logic          w_pick;

  logic          r_winner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [BW-1:0] r_be;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata;

  sm_rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req0   (p0_if.req),
    .i_req1   (p1_if.req),
    .i_update (w_latch),
    .o_any    (w_any),
    .o_pick   (w_pick)
  );

  // Sequencer state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, latch strobe, grant and memory strobe decode.
  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    p0_if.gnt    = 1'b0;
    p1_if.gnt    = 1'b0;
    o_mem_en     = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_be     = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_latch      = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_mem_en     = 1'b1;
        o_mem_we     = r_we;
        o_mem_be     = r_be;
        p0_if.gnt    = ~r_winner;
        p1_if.gnt    = r_winner;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Capture the winner's request fields; they drive the RAM during ISSUE
  // and simply hold afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_winner <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
    end else if (w_latch) begin
      r_winner <= w_pick;
      r_we     <= w_pick ? p1_if.we    : p0_if.we;
      r_addr   <= w_pick ? p1_if.addr  : p0_if.addr;
      r_wdata  <= w_pick ? p1_if.wdata : p0_if.wdata;
      r_be     <= w_pick ? p1_if.be    : p0_if.be;
    end
  end

  // Register RAM read data in WAIT and pulse the winner's completion next cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid0 <= (r_state == S_WAIT) && !r_winner;
      r_rvalid1 <= (r_state == S_WAIT) &&  r_winner;
      if (r_state == S_WAIT) begin
        r_rdata <= i_mem_rdata;
      end
    end
  end

  assign p0_if.rvalid = r_rvalid0;
  assign p1_if.rvalid = r_rvalid1;
  assign o_rdata      = r_rdata;
  assign o_busy       = (r_state != S_IDLE);
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;

endmodule
